// File: rtl/gain_capture.sv
// Windowed DC/AC capture: averages 2^LOG2_WIN samples and reports mean plus peak-to-peak swing.
// Peak tracking is built only when GAIN_CAPTURE_PEAK_EN is defined; otherwise out_pk2pk is 0.
module gain_capture #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned LOG2_WIN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_mean,
  output logic        [WIDTH:0]   out_pk2pk,
  output logic                    busy
);

  localparam int unsigned AccW = WIDTH + LOG2_WIN;

  typedef enum logic [1:0] {StIdle, StAccum, StReport} state_e;

  state_e                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic [LOG2_WIN-1:0]    cnt_q, cnt_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [AccW-1:0] sample_ext, acc_sum, acc_shift;
  logic signed [WIDTH-1:0] mean_q, mean_d;
  logic                   accept, last;

  // in_ready_q mirrors state_q == StAccum, so it doubles as the accept qualifier
  assign accept = in_valid & in_ready_q;
  assign last   = accept && (cnt_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start)     state_d = StAccum;
      StAccum:  if (last)      state_d = StReport;
      StReport: if (out_ready) state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    in_ready_d  = (state_d == StAccum);
    out_valid_d = (state_d == StReport);
    busy_d      = (state_d != StIdle);
  end

  always_comb begin
    sample_ext = {{LOG2_WIN{in_data[WIDTH-1]}}, in_data};
    acc_sum    = acc_q + sample_ext;
    acc_shift  = acc_sum >>> LOG2_WIN;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mean_d     = mean_q;
    if (state_q == StIdle && start) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + LOG2_WIN'(1);
      if (last) mean_d = acc_shift[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mean_q      <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mean_q      <= mean_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_mean  = mean_q;

`ifdef GAIN_CAPTURE_PEAK_EN
  logic signed [WIDTH-1:0] min_q, min_d, max_q, max_d;
  logic        [WIDTH:0]   pk_q, pk_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    pk_d  = pk_q;
    if (accept) begin
      if (cnt_q == '0) begin
        min_d = in_data;
        max_d = in_data;
      end else begin
        if (in_data < min_q) min_d = in_data;
        if (in_data > max_q) max_d = in_data;
      end
      // One extra bit keeps full-scale swings non-negative
      if (last) pk_d = {max_d[WIDTH-1], max_d} - {min_d[WIDTH-1], min_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
      pk_q  <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      pk_q  <= pk_d;
    end
  end

  assign out_pk2pk = pk_q;
`else
  assign out_pk2pk = '0;
`endif

endmodule

// File: tb/tb_gain_capture.sv
// Randomised scoreboard bench for gain_capture; expected mean/swing come from plain arithmetic.
module tb_gain_capture;

  localparam int W = 12;
  localparam int L = 4;
  localparam int N = 1 << L;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] out_mean;
  logic        [W:0]   out_pk2pk;
  logic                busy;

  gain_capture #(.WIDTH(W), .LOG2_WIN(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mean  (out_mean),
    .out_pk2pk (out_pk2pk),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mean;
    int pk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_results = 0;
  int   n_windows = 0;
  int   stall_len = 0;
  int   hold_cnt  = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Consumer back-pressure: hold out_ready low for stall_len cycles of each result
  always begin
    @(posedge clk);
    #1;
    if (out_valid && hold_cnt < stall_len) begin
      out_ready = 1'b0;
      hold_cnt++;
    end else begin
      out_ready = 1'b1;
      if (!out_valid) hold_cnt = 0;
    end
  end

  // Monitor: every cycle a result is shown it must match the head of the scoreboard
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: mean %0d pk2pk %0d with empty scoreboard",
                 int'(out_mean), int'(out_pk2pk));
      end else begin
        check("mean", int'(out_mean), exp_q[0].mean);
        check("pk2pk", int'(out_pk2pk), exp_q[0].pk);
        check("in_ready_in_report", int'(in_ready), 0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_results++;
        end
      end
    end
  end

  function automatic int sample_val(input int mode, input int cval, input int i);
    logic [W-1:0] r;
    case (mode)
      0:       return cval;
      1:       return (i % 2 == 0) ? 2047 : -2048;
      default: begin
        r = W'($urandom);
        return int'($signed(r));
      end
    endcase
  endfunction

  task automatic wait_ready();
    int cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) check("in_ready_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic run_window(input int mode, input int cval, input bit gaps, input bit start_mid);
    int   v[$];
    int   sum = 0;
    int   mn, mx, q, cyc;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      v.push_back(sample_val(mode, cval, i));
      sum += v[i];
      if (i == 0 || v[i] < mn) mn = v[i];
      if (i == 0 || v[i] > mx) mx = v[i];
    end
    q = sum / N;
    if (sum % N != 0 && sum < 0) q--;
    e.mean = q;
`ifdef GAIN_CAPTURE_PEAK_EN
    e.pk = mx - mn;
`else
    e.pk = 0;
`endif
    exp_q.push_back(e);
    n_windows++;

    pulse_start();
    for (int i = 0; i < N; i++) begin
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = v[i][W-1:0];
      if (start_mid && i == 5) start = 1'b1;
      wait_ready();
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    check("out_valid_latency", int'(out_valid), 1);

    if (start_mid) begin
      cyc = 0;
      while (!(out_valid && out_ready) && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check("busy_idle_after", int'(busy), 0);
    check("out_valid_idle_after", int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mean", int'(out_mean), 0);
    check("rst_pk2pk", int'(out_pk2pk), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_window(0, 100, 1'b0, 1'b0);
    run_window(1, 0, 1'b0, 1'b0);

    stall_len = 5;
    run_window(2, 0, 1'b1, 1'b0);
    stall_len = 0;

    // Abort a window after 7 samples; nothing may be reported for it
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i * 37 - 50);
      wait_ready();
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_mean", int'(out_mean), 0);
    check("midrst_pk2pk", int'(out_pk2pk), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_quiet", int'(out_valid | busy), 0);
    end

    run_window(0, -5, 1'b0, 1'b0);
    run_window(2, 0, 1'b0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      stall_len = $urandom_range(0, 3);
      run_window(2, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    stall_len = 0;

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("result_count", n_results, n_windows);
    check("final_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gain_capture.md
GAIN_CAPTURE -- requirements
Module: gain_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 12: sample width, signed two's complement.
REQ-002 SHALL have parameter LOG2_WIN, default 4: window length N = 2^LOG2_WIN samples, legal range 1..8.
REQ-003 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin one capture window.
REQ-006 SHALL have port in_valid  input  1  sample present on in_data.
REQ-007 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  signed sample from the measured node.
REQ-009 SHALL have port out_valid  output  1  result present on out_mean/out_pk2pk.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port out_mean  output  WIDTH  signed window mean (DC level).
REQ-012 SHALL have port out_pk2pk  output  WIDTH+1  unsigned max minus min (AC swing).
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, REPORT; only legal transitions IDLE->ACCUM, ACCUM->REPORT, REPORT->IDLE.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 -> ACCUM next cycle, accumulator and sample counter cleared.
REQ-016 ACCUM: in_ready=1; a sample is accepted only on cycles with in_valid && in_ready; gaps in in_valid stall without loss.
REQ-017 Each accepted sample SHALL be sign-extended and added into a WIDTH+LOG2_WIN-bit accumulator; no overflow possible at any N.
REQ-018 First accepted sample of a window SHALL load both running min and max; later samples update them by signed compare.
REQ-019 On acceptance of sample N (counter = N-1), FSM SHALL enter REPORT next cycle; out_valid rises that cycle (latency 1 from final accept).
REQ-020 out_mean SHALL equal accumulator arithmetically shifted right by LOG2_WIN (floor toward minus infinity).
REQ-021 out_pk2pk SHALL equal max - min computed in WIDTH+1 bits, always non-negative.
REQ-022 REPORT: in_ready=0; out_valid, out_mean, out_pk2pk held stable until out_valid && out_ready, then IDLE next cycle with out_valid=0.
REQ-023 start SHALL be ignored in ACCUM and REPORT; start coincident with the REPORT handshake SHALL NOT begin a new window.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 rst_n low SHALL force IDLE immediately, regardless of clk.
REQ-026 Reset values: in_ready=0, out_valid=0, busy=0, out_mean=0, out_pk2pk=0; accumulator, counter, min, max cleared.
REQ-027 Reset mid-ACCUM or mid-REPORT SHALL discard partial window/pending result; no result emitted afterwards.

Configuration
REQ-028 Macro GAIN_CAPTURE_PEAK_EN defined: min/max tracking and out_pk2pk per REQ-018/021.
REQ-029 Macro GAIN_CAPTURE_PEAK_EN undefined: min/max registers omitted, out_pk2pk constant 0; mean path and timing unchanged.

Verification
REQ-030 start, then 16 samples of +100 back-to-back, out_ready=1 -> out_valid 1 cycle after 16th accept, out_mean=100, out_pk2pk=0.
REQ-031 16 samples alternating +2047/-2048 -> out_mean=-1, out_pk2pk=4095 (0 with macro undefined).
REQ-032 in_valid toggling every other cycle, out_ready low 5 cycles after out_valid -> all 16 samples counted, results stable, in_ready=0 throughout stall.
REQ-033 rst_n pulsed low after 7 accepted samples -> IDLE, out_valid stays 0; fresh start + 16 samples of -5 -> out_mean=-5.
REQ-034 start pulsed during ACCUM and coincident with REPORT handshake -> ignored; exactly one result per accepted start, then IDLE with busy=0.
